// File: rtl/localmem_bist_pkg.sv
// rtl/localmem_bist_pkg.sv - shared types and phase helpers for the dmem BIST sequencer
package localmem_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BW,
    ST_BR,
    ST_SR,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [1:0] PHASE_IDLE = 2'd0;
  localparam logic [1:0] PHASE_BW   = 2'd1;
  localparam logic [1:0] PHASE_BR   = 2'd2;
  localparam logic [1:0] PHASE_SR   = 2'd3;

  localparam int PH_BW = 0;
  localparam int PH_BR = 1;
  localparam int PH_SR = 2;

  // Next enabled phase after cur; drain only when some read phase exists in the run.
  function automatic state_e next_phase(input state_e cur, input logic [2:0] en);
    state_e nxt;
    if (cur == ST_IDLE && en[PH_BW]) begin
      nxt = ST_BW;
    end else if ((cur == ST_IDLE || cur == ST_BW) && en[PH_BR]) begin
      nxt = ST_BR;
    end else if (cur != ST_SR && en[PH_SR]) begin
      nxt = ST_SR;
    end else if (en[PH_BR] || en[PH_SR]) begin
      nxt = ST_DRAIN;
    end else begin
      nxt = ST_DONE;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bist_cmp_pipe.sv
// rtl/bist_cmp_pipe.sv - read-latency delay line, registered comparator and saturating error counter
module bist_cmp_pipe #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              flush_i,
  input  logic              iss_valid_i,
  input  logic [DATA_W-1:0] iss_exp_i,
  input  logic [ADDR_W-1:0] iss_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [ADDR_W-1:0] first_err_a_o
);

  logic [RD_LAT-1:0]             vld_q;
  logic [RD_LAT-1:0][DATA_W-1:0] exp_q;
  logic [RD_LAT-1:0][ADDR_W-1:0] adr_q;
  logic [ERR_W-1:0]              err_q, err_d;
  logic [ADDR_W-1:0]             first_q, first_d;
  logic                          mism;

  // Carry each issued read alongside its expected word until o2 is valid; abort empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      exp_q <= '0;
      adr_q <= '0;
    end else begin
      vld_q[0] <= iss_valid_i;
      exp_q[0] <= iss_exp_i;
      adr_q[0] <= iss_addr_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
        adr_q[i] <= adr_q[i-1];
      end
      if (flush_i) begin
        vld_q <= '0;
      end
    end
  end

  assign mism = vld_q[RD_LAT-1] && (rd_data_i != exp_q[RD_LAT-1]);

  // Count mismatches (holding at all-ones) and capture only the first failing address.
  always_comb begin
    err_d   = err_q;
    first_d = first_q;
    if (clr_i) begin
      err_d   = '0;
      first_d = '0;
    end else if (mism && !flush_i) begin
      if (err_q != '1) begin
        err_d = err_q + 1'b1;
      end
      if (err_q == '0) begin
        first_d = adr_q[RD_LAT-1];
      end
    end
  end

  // Error result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= '0;
      first_q <= '0;
    end else begin
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign err_cnt_o     = err_q;
  assign first_err_a_o = first_q;

endmodule

// File: rtl/dmem_bist_ctrl.sv
// rtl/dmem_bist_ctrl.sv - dmem BIST sequencer: burst write, burst read, sequential read
module dmem_bist_ctrl
  import localmem_bist_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 10,
  parameter int SEL_W  = 2,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        phase_en,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_a,
  output logic [1:0]        phase,
  output logic              mode,
  output logic              web1,
  output logic              oeb1,
  output logic [ADDR_W-1:0] a1,
  output logic [DATA_W-1:0] i1,
  output logic              web2,
  output logic              oeb2,
  output logic [ADDR_W-1:0] a2,
  input  logic [DATA_W-1:0] o2
);

  localparam int                ROWS       = 1 << (ADDR_W - SEL_W);
  localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
  localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(RD_LAT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [2:0]        en_q, en_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d, mode_q, mode_d;
  logic [1:0]        phase_q, phase_d;
  logic              web1_q, web1_d, oeb1_q, oeb1_d, oeb2_q, oeb2_d;
  logic [ADDR_W-1:0] a1_q, a1_d, a2_q, a2_d;
  logic [DATA_W-1:0] i1_q, i1_d, exp_q, exp_d;
  logic              start_acc;
  logic [ERR_W-1:0]  err_cnt_w;

  assign start_acc = (state_q == ST_IDLE) && start && !abort;

  // Phase sequencing: one access per cycle, each phase hands over to the next with no bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    en_d    = en_q;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d = next_phase(ST_IDLE, phase_en);
          cnt_d   = '0;
          seed_d  = seed;
          en_d    = phase_en;
        end
      end
      ST_BW, ST_BR: begin
        if (cnt_q == ROW_LAST) begin
          state_d = next_phase(state_q, en_q);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_LAST) begin
          state_d = next_phase(ST_SR, en_q);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // Port and status values for the upcoming cycle, derived from the next state so outputs stay registered.
  always_comb begin
    busy_d  = (state_d == ST_BW) || (state_d == ST_BR) || (state_d == ST_SR) || (state_d == ST_DRAIN);
    done_d  = (state_d == ST_DONE);
    mode_d  = (state_d == ST_SR);
    web1_d  = (state_d != ST_BW);
    oeb1_d  = (state_d != ST_BW);
    oeb2_d  = !((state_d == ST_BR) || (state_d == ST_SR));
    a1_d    = a1_q;
    i1_d    = i1_q;
    a2_d    = a2_q;
    exp_d   = exp_q;
    phase_d = PHASE_IDLE;
    case (state_d)
      ST_BW: begin
        phase_d = PHASE_BW;
        a1_d    = cnt_d << SEL_W;
        i1_d    = seed_d + DATA_W'(cnt_d);
      end
      ST_BR: begin
        phase_d = PHASE_BR;
        a2_d    = cnt_d << SEL_W;
        exp_d   = seed_d + DATA_W'(cnt_d);
      end
      ST_SR: begin
        phase_d = PHASE_SR;
        a2_d    = cnt_d;
        exp_d   = seed_d + DATA_W'(cnt_d >> SEL_W);
      end
      default: phase_d = PHASE_IDLE;
    endcase
    // A run with no phases reaches DONE in the start cycle, before the counter clear lands.
    if (state_d == ST_DONE) begin
      pass_d = start_acc || (err_cnt_w == '0);
    end else if (start_acc) begin
      pass_d = 1'b0;
    end else begin
      pass_d = pass_q;
    end
  end

  // State, run context and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      seed_q  <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mode_q  <= 1'b0;
      phase_q <= PHASE_IDLE;
      web1_q  <= 1'b1;
      oeb1_q  <= 1'b1;
      oeb2_q  <= 1'b1;
      a1_q    <= '0;
      i1_q    <= '0;
      a2_q    <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      web1_q  <= web1_d;
      oeb1_q  <= oeb1_d;
      oeb2_q  <= oeb2_d;
      a1_q    <= a1_d;
      i1_q    <= i1_d;
      a2_q    <= a2_d;
      exp_q   <= exp_d;
    end
  end

  bist_cmp_pipe #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT),
    .ERR_W (ERR_W)
  ) u_cmp (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (start_acc),
    .flush_i      (abort),
    .iss_valid_i  (!oeb2_q),
    .iss_exp_i    (exp_q),
    .iss_addr_i   (a2_q),
    .rd_data_i    (o2),
    .err_cnt_o    (err_cnt_w),
    .first_err_a_o(first_err_a)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_cnt_w;
  assign phase   = phase_q;
  assign mode    = mode_q;
  assign web1    = web1_q;
  assign oeb1    = oeb1_q;
  assign a1      = a1_q;
  assign i1      = i1_q;
  assign web2    = 1'b1;
  assign oeb2    = oeb2_q;
  assign a2      = a2_q;

endmodule
